// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query bus between the pipeline control and hazard_scoreboard.
// master = pipeline side driving the ID instruction, slave = the scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_BITS = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2
);
    logic                    id_valid;
    logic                    id_wreg;
    logic                    id_is_load;
    logic [REG_BITS-1:0]     id_dst;
    logic [REG_BITS-1:0]     id_rs;
    logic [REG_BITS-1:0]     id_rt;
    logic                    id_rd_rs;
    logic                    id_rd_rt;
    logic [DATA_W-1:0]       id_a;
    logic [DATA_W-1:0]       id_b;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    flush;
    logic                    stall;
    logic [DATA_W-1:0]       a_out;
    logic [DATA_W-1:0]       b_out;
    logic [15:0]             stall_cycles;

    modport master (
        output id_valid, id_wreg, id_is_load, id_dst, id_rs, id_rt,
               id_rd_rs, id_rd_rt, id_a, id_b, stage_data, flush,
        input  stall, a_out, b_out, stall_cycles
    );

    modport slave (
        input  id_valid, id_wreg, id_is_load, id_dst, id_rs, id_rt,
               id_rd_rs, id_rd_rt, id_a, id_b, stage_data, flush,
        output stall, a_out, b_out, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers after ID and resolves RAW hazards by stalling.
// Define HAZARD_SCOREBOARD_FORWARD_EN to forward from stage_data and stall only on load-use.
module hazard_scoreboard #(
    parameter int REG_BITS = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus
);
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_load;
    logic [REG_BITS-1:0] ent_dst [DEPTH];
    logic [15:0]         stall_cnt;

    logic [DEPTH-1:0]    rs_hit;
    logic [DEPTH-1:0]    rt_hit;
    logic                raw_hazard;
    logic                stall;

    // Register 0 is hardwired, so a zero source can never hit an entry.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rs_hit[k] = bus.id_rd_rs && ent_valid[k] &&
                        (ent_dst[k] == bus.id_rs) && (bus.id_rs != '0);
            rt_hit[k] = bus.id_rd_rt && ent_valid[k] &&
                        (ent_dst[k] == bus.id_rt) && (bus.id_rt != '0);
        end
    end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    logic [DATA_W-1:0] a_fwd;
    logic [DATA_W-1:0] b_fwd;

    // Walk from the oldest entry down so the youngest match wins.
    always_comb begin
        a_fwd = bus.id_a;
        b_fwd = bus.id_b;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_hit[k]) a_fwd = bus.stage_data[k*DATA_W +: DATA_W];
            if (rt_hit[k]) b_fwd = bus.stage_data[k*DATA_W +: DATA_W];
        end
    end

    assign raw_hazard = ent_load[0] && (rs_hit[0] || rt_hit[0]);
    assign bus.a_out  = a_fwd;
    assign bus.b_out  = b_fwd;
`else
    logic unused_fwd;

    assign unused_fwd = ^{bus.stage_data, ent_load};
    assign raw_hazard = |{rs_hit, rt_hit};
    assign bus.a_out  = bus.id_a;
    assign bus.b_out  = bus.id_b;
`endif

    assign stall            = bus.id_valid && !bus.flush && raw_hazard;
    assign bus.stall        = stall;
    assign bus.stall_cycles = stall_cnt;

    // A stalled or flushed ID instruction enters as a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_load[k]  <= 1'b0;
                ent_dst[k]   <= '0;
            end
            stall_cnt <= '0;
        end else begin
            ent_valid[0] <= bus.id_valid && bus.id_wreg && (bus.id_dst != '0) &&
                            !stall && !bus.flush;
            ent_dst[0]   <= bus.id_dst;
            ent_load[0]  <= bus.id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_dst[k]   <= ent_dst[k-1];
                ent_load[k]  <= ent_load[k-1];
            end
            if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard, covering both resolution modes
// (HAZARD_SCOREBOARD_FORWARD_EN defined or not); a DEPTH=4 instance exercises saturation.
module tb_hazard_scoreboard;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [15:0] CNT_BASE = FWD ? 16'd1 : 16'd2;

    typedef struct {
        bit          sat;
        logic        stall;
        bit          chk_ab;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_BITS(5), .DATA_W(32), .DEPTH(2)) bus ();
    hazard_scoreboard_if #(.REG_BITS(5), .DATA_W(32), .DEPTH(4)) sat_bus ();

    hazard_scoreboard #(.REG_BITS(5), .DATA_W(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hazard_scoreboard #(.REG_BITS(5), .DATA_W(32), .DEPTH(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus)
    );

    // Drives one ID instruction at the falling edge and queues what the DUT must show.
    task automatic applyStimulus(input string tag, input logic v, input logic w, input logic ld,
                                 input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [31:0] a, input logic [31:0] b, input logic fl,
                                 input logic es, input logic chk, input logic [31:0] ea,
                                 input logic [31:0] eb, input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_wreg    = w;
        bus.id_is_load = ld;
        bus.id_dst     = dst;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd_rs   = 1'b1;
        bus.id_rd_rt   = 1'b1;
        bus.id_a       = a;
        bus.id_b       = b;
        bus.flush      = fl;
        e.sat    = 1'b0;
        e.stall  = es;
        e.chk_ab = chk;
        e.a      = ea;
        e.b      = eb;
        e.cnt    = ec;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pops the oldest expectation and compares it against the settled outputs.
    task automatic checkOutput();
        exp_t        e;
        string       tag;
        logic        os;
        logic [31:0] oa;
        logic [31:0] ob;
        logic [15:0] oc;
        #1;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        os  = e.sat ? sat_bus.stall        : bus.stall;
        oa  = e.sat ? sat_bus.a_out        : bus.a_out;
        ob  = e.sat ? sat_bus.b_out        : bus.b_out;
        oc  = e.sat ? sat_bus.stall_cycles : bus.stall_cycles;
        checks++;
        assert (os === e.stall) else begin
            failures++;
            $error("[TB] FAIL %s.stall observed=%0b expected=%0b", tag, os, e.stall);
        end
        if (e.chk_ab) begin
            checks++;
            assert (oa === e.a) else begin
                failures++;
                $error("[TB] FAIL %s.a_out observed=%0h expected=%0h", tag, oa, e.a);
            end
            checks++;
            assert (ob === e.b) else begin
                failures++;
                $error("[TB] FAIL %s.b_out observed=%0h expected=%0h", tag, ob, e.b);
            end
        end
        checks++;
        assert (oc === e.cnt) else begin
            failures++;
            $error("[TB] FAIL %s.stall_cycles observed=%0d expected=%0d", tag, oc, e.cnt);
        end
    endtask

    task automatic satCheck(input string tag, input int edges, input logic es, input logic [15:0] ec);
        exp_t e;
        repeat (edges) @(posedge clk);
        e.sat    = 1'b1;
        e.stall  = es;
        e.chk_ab = 1'b0;
        e.a      = '0;
        e.b      = '0;
        e.cnt    = ec;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        checkOutput();
    endtask

    initial begin
        rst = 1'b0;
        bus.id_valid = 0; bus.id_wreg = 0; bus.id_is_load = 0; bus.id_dst = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd_rs = 0; bus.id_rd_rt = 0;
        bus.id_a = 0; bus.id_b = 0; bus.stage_data = '0; bus.flush = 0;
        sat_bus.id_valid = 0; sat_bus.id_wreg = 0; sat_bus.id_is_load = 0; sat_bus.id_dst = 0;
        sat_bus.id_rs = 0; sat_bus.id_rt = 0; sat_bus.id_rd_rs = 0; sat_bus.id_rd_rt = 0;
        sat_bus.id_a = 0; sat_bus.id_b = 0; sat_bus.stage_data = '0; sat_bus.flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("post_reset", 1, 0, 0, 5'd0, 5'd3, 5'd4, 32'h1, 32'h2, 0, 0, 1, 32'h1, 32'h2, 16'd0);
        checkOutput();
        applyStimulus("add3", 1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h11, 32'h22, 0, 0, 1, 32'h11, 32'h22, 16'd0);
        checkOutput();

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        applyStimulus("gap", 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 1, 32'h1, 32'h2, 16'd0);
        checkOutput();
        bus.stage_data = {32'h5, 32'h66};
        applyStimulus("or3_mem", 1, 1, 0, 5'd8, 5'd3, 5'd0, 32'hAA, 32'hBB, 0, 0, 1, 32'h5, 32'hBB, 16'd0);
        checkOutput();
        applyStimulus("add3_x", 1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h11, 32'h22, 0, 0, 1, 32'h11, 32'h22, 16'd0);
        checkOutput();
        applyStimulus("add3_y", 1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h11, 32'h22, 0, 0, 1, 32'h11, 32'h22, 16'd0);
        checkOutput();
        bus.stage_data = {32'h66, 32'h5};
        applyStimulus("or3_ex_pri", 1, 1, 0, 5'd8, 5'd3, 5'd0, 32'hAA, 32'hBB, 0, 0, 1, 32'h5, 32'hBB, 16'd0);
        checkOutput();
        applyStimulus("lw4", 1, 1, 1, 5'd4, 5'd0, 5'd0, 32'h11, 32'h22, 0, 0, 1, 32'h11, 32'h22, 16'd0);
        checkOutput();
        bus.stage_data = {32'h1234, 32'h9999};
        applyStimulus("use4_a", 1, 1, 0, 5'd9, 5'd0, 5'd4, 32'hAA, 32'hBB, 0, 1, 0, 32'h0, 32'h0, 16'd0);
        checkOutput();
        applyStimulus("use4_b", 1, 1, 0, 5'd9, 5'd0, 5'd4, 32'hAA, 32'hBB, 0, 0, 1, 32'hAA, 32'h1234, 16'd1);
        checkOutput();
`else
        bus.stage_data = {32'h0, 32'h5};
        applyStimulus("use3_a", 1, 1, 0, 5'd6, 5'd3, 5'd0, 32'hAA, 32'hBB, 0, 1, 1, 32'hAA, 32'hBB, 16'd0);
        checkOutput();
        applyStimulus("use3_b", 1, 1, 0, 5'd6, 5'd3, 5'd0, 32'hAA, 32'hBB, 0, 1, 1, 32'hAA, 32'hBB, 16'd1);
        checkOutput();
        applyStimulus("use3_c", 1, 1, 0, 5'd6, 5'd3, 5'd0, 32'hAA, 32'hBB, 0, 0, 1, 32'hAA, 32'hBB, 16'd2);
        checkOutput();
`endif

        applyStimulus("lw6", 1, 1, 1, 5'd6, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 1, 32'h1, 32'h2, CNT_BASE);
        checkOutput();
        applyStimulus("rst_mid", 1, 0, 0, 5'd0, 5'd0, 5'd6, 32'h3, 32'h4, 0, 1, !FWD, 32'h3, 32'h4, CNT_BASE);
        rst = 1'b0;
        checkOutput();
        applyStimulus("after_rst", 1, 0, 0, 5'd0, 5'd0, 5'd6, 32'h3, 32'h4, 0, 0, 1, 32'h3, 32'h4, 16'd0);
        rst = 1'b1;
        checkOutput();

        applyStimulus("w0", 1, 1, 0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 1, 32'h1, 32'h2, 16'd0);
        checkOutput();
        applyStimulus("r0", 1, 1, 0, 5'd0, 5'd0, 5'd0, 32'h77, 32'h88, 0, 0, 1, 32'h77, 32'h88, 16'd0);
        checkOutput();

        applyStimulus("w5", 1, 1, 0, 5'd5, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 1, 32'h1, 32'h2, 16'd0);
        checkOutput();
        bus.stage_data = {32'h0, 32'h55};
        applyStimulus("flush", 1, 1, 0, 5'd7, 5'd5, 5'd0, 32'hA1, 32'hB1, 1, 0, 1,
                      FWD ? 32'h55 : 32'hA1, 32'hB1, 16'd0);
        checkOutput();
        bus.stage_data = {32'h5A5, 32'h777};
        applyStimulus("post_flush", 1, 0, 0, 5'd0, 5'd7, 5'd5, 32'hC1, 32'hD1, 0, !FWD, 1,
                      32'hC1, FWD ? 32'h5A5 : 32'hD1, 16'd0);
        checkOutput();
        applyStimulus("idle_end", 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 1,
                      32'h1, 32'h2, FWD ? 16'd0 : 16'd1);
        checkOutput();

`ifndef HAZARD_SCOREBOARD_FORWARD_EN
        // Self-dependent writer of $3 keeps the DEPTH=4 instance stalling 4 of every 5 cycles.
        @(negedge clk);
        rst = 1'b0;
        sat_bus.id_valid = 1; sat_bus.id_wreg = 1; sat_bus.id_dst = 5'd3;
        sat_bus.id_rs = 5'd3; sat_bus.id_rd_rs = 1;
        @(negedge clk);
        rst = 1'b1;
        satCheck("sat_early", 10, 0, 16'd8);
        satCheck("sat_near", 81908, 1, 16'd65534);
        satCheck("sat_hold", 12, 0, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
